priority_arbiter_n: RTL and testbench
=====================================

PRIORITY_ARBITER_N -- requirements
Module: priority_arbiter_n

Interface
REQ-001 SHALL have parameter N: default 8; number of request lines, legal range 2..32, need not be a power of two.
REQ-002 SHALL have parameter RR_MODE: default 1; 0 = fixed priority, 1 = round-robin.
REQ-003 SHALL define local constant W = clog2(N): width of index output Y.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port D  input  N  request vector; bit i = requester i active.
REQ-007 SHALL have port Ack  input  1  consumer accepts the current grant this cycle.
REQ-008 SHALL have port Y  output  W  registered index of granted requester.
REQ-009 SHALL have port Gnt  output  N  registered one-hot grant, equal to 1 << Y when Vld=1, else all zero.
REQ-010 SHALL have port Vld  output  1  registered, grant present.

Function
REQ-011 SHALL be "free" when Vld=0 or (Vld=1 and Ack=1); "holding" when Vld=1 and Ack=0.
REQ-012 SHALL, when free, arbitrate D combinationally and load Y/Gnt/Vld on the next edge: one-cycle latency from D to Vld.
REQ-013 SHALL, when free and D=0, load Vld=0, Y=0, Gnt=0.
REQ-014 SHALL, when holding, keep Y, Gnt and Vld unchanged regardless of D, including deassertion of the granted bit.
REQ-015 SHALL ignore Ack when Vld=0.
REQ-016 SHALL, when Vld=1 and Ack=1, arbitrate the current D in the same cycle, giving back-to-back grants with no bubble.
REQ-017 SHALL, with RR_MODE=0, grant the highest set index of D (D[N-1] highest priority).
REQ-018 SHALL, with RR_MODE=1, maintain a W-bit pointer ptr naming the highest-priority index.
REQ-019 SHALL make the search order in round-robin mode ptr, ptr-1, ... 0, N-1, ... ptr+1 (descending, wrapping).
REQ-020 SHALL update ptr only on an accepted grant (Vld=1 and Ack=1): ptr <= (Y==0) ? N-1 : Y-1.
REQ-021 SHALL hold ptr in all other cycles and not use it when RR_MODE=0.
REQ-022 SHALL implement wrap-around for non-power-of-two N within 0..N-1; Y SHALL never exceed N-1.
REQ-023 SHALL give a requester that is the only one set a grant on every free cycle in either mode.

Reset
REQ-024 SHALL, while rst=1 at an edge, set Vld=0, Y=0, Gnt=0 and ptr=N-1, overriding Ack and D.
REQ-025 SHALL abandon any grant that is holding when reset is applied mid-operation, with no ptr update.
REQ-026 SHALL begin normal arbitration on the first edge after rst deasserts.

Structure
REQ-027 SHALL keep mode constants MODE_FIXED=0 and MODE_RR=1 in shared package priority_pkg, along with the clog2 helper.
REQ-028 SHALL instantiate sub-module priority_find_hi (N in, W index + any-valid out, combinational highest-set-bit finder) twice.
REQ-029 SHALL use the two instances as follows: one on D masked to indices <= ptr, one on unmasked D; use the masked result if any, else the unmasked one.
REQ-030 SHALL bypass the mask in fixed mode.
REQ-031 SHALL register only Y, Gnt, Vld and ptr.

Verification (N=8)
REQ-032 SHALL cover reset: rst=1 for 2 cycles with D=8'hFF -> Vld=0, Y=0, Gnt=0; first grant after release is Y=7.
REQ-033 SHALL cover fixed mode: RR_MODE=0, D=8'b0010_1100, Ack=1 -> next cycle Y=5, Gnt=8'h20, Vld=1; repeats every cycle.
REQ-034 SHALL cover hold: D=8'h0C, Ack=0 -> Y=3, Vld=1; D changes to 8'h80 -> Y stays 3 until Ack=1, then Y=7 next cycle.
REQ-035 SHALL cover round-robin sweep: RR_MODE=1, D=8'hFF, Ack=1 continuous -> Y = 7,6,5,4,3,2,1,0,7.
REQ-036 SHALL cover round-robin sparse: D=8'h81, Ack=1 -> Y alternates 7,0,7,0; D=0 -> Vld=0 next cycle.
REQ-037 SHALL cover mid-hold reset and odd N: reset while holding Y=5 -> Vld=0, next D=8'hFF gives Y=7; N=5, D=5'h1F, Ack=1 -> Y = 4,3,2,1,0,4.

Source files
------------

// File: rtl/priority_pkg.sv
// priority_pkg
//   Shared constants and helpers for the priority arbiter slice.
//   MODE_FIXED / MODE_RR : values for the arbiter RR_MODE parameter.
//   clog2(n)             : index width for n requesters (minimum 1 bit).
package priority_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/priority_find_hi.sv
// priority_find_hi
//   Combinational highest-set-bit finder.
//   Ports:
//     d   [N-1:0] in  : candidate vector
//     idx [W-1:0] out : index of the highest set bit of d (0 when d is zero)
//     any         out : d has at least one bit set
module priority_find_hi
    import priority_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n
//   N-way arbiter with registered grant, fixed-priority or round-robin.
//   Ports:
//     clk          in  : clock, all state on rising edge
//     rst          in  : synchronous active-high reset
//     D   [N-1:0]  in  : request vector, bit i = requester i active
//     Ack          in  : consumer accepts the current grant this cycle
//     Y   [W-1:0]  out : registered index of granted requester
//     Gnt [N-1:0]  out : registered one-hot grant (1 << Y when Vld, else 0)
//     Vld          out : registered grant-present flag
//   A grant is held until accepted; on acceptance the next grant is chosen
//   in the same cycle so consecutive grants have no bubble.
module priority_arbiter_n
    import priority_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = 1,
    localparam int W      = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         Ack,
    output logic [W-1:0] Y,
    output logic [N-1:0] Gnt,
    output logic         Vld
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_eff;
    logic         accept;
    logic         free;
    logic [N-1:0] mask;
    logic [N-1:0] d_masked;
    logic [W-1:0] idx_m;
    logic [W-1:0] idx_u;
    logic         any_m;
    logic         any_u;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic [N-1:0] gnt_nxt;

    assign accept = Vld & Ack;
    assign free   = ~Vld | Ack;

    // On an accepted grant the search must already use the advanced pointer,
    // otherwise the just-served requester would win again.
    always_comb begin
        ptr_eff = ptr;
        if (accept) begin
            ptr_eff = (Y == '0) ? W'(N - 1) : (Y - W'(1));
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i <= int'(ptr_eff));
        end
    end

    assign d_masked = (RR_MODE == MODE_RR) ? (D & mask) : D;

    priority_find_hi #(.N(N)) u_find_masked (
        .d   (d_masked),
        .idx (idx_m),
        .any (any_m)
    );

    priority_find_hi #(.N(N)) u_find_all (
        .d   (D),
        .idx (idx_u),
        .any (any_u)
    );

    // Nothing at or below ptr means the search wraps to the top: the plain
    // highest-set-bit of D is then exactly the next index in wrap order.
    always_comb begin
        sel_any = any_u;
        sel_idx = idx_u;
        if ((RR_MODE == MODE_RR) && any_m) begin
            sel_idx = idx_m;
        end
        if (!sel_any) begin
            sel_idx = '0;
        end
    end

    always_comb begin
        gnt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            gnt_nxt[i] = sel_any && (sel_idx == W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Vld <= 1'b0;
            Y   <= '0;
            Gnt <= '0;
        end else if (free) begin
            Vld <= sel_any;
            Y   <= sel_idx;
            Gnt <= gnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= W'(N - 1);
        end else if (accept && (RR_MODE == MODE_RR)) begin
            ptr <= ptr_eff;
        end
    end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// tb_priority_arbiter_n
//   Directed bench: round-robin N=8, fixed-priority N=8 and round-robin N=5
//   instances share clock, reset and Ack; each scenario checks one of them.
module tb_priority_arbiter_n;

    logic       clk;
    logic       rst;
    logic       ack;
    logic [7:0] d8;
    logic [4:0] d5;

    logic [2:0] y_rr;
    logic [7:0] gnt_rr;
    logic       vld_rr;
    logic [2:0] y_fx;
    logic [7:0] gnt_fx;
    logic       vld_fx;
    logic [2:0] y_n5;
    logic [4:0] gnt_n5;
    logic       vld_n5;

    int checks;
    int errors;

    priority_arbiter_n #(.N(8), .RR_MODE(1)) dut_rr (
        .clk (clk), .rst (rst), .D (d8), .Ack (ack),
        .Y (y_rr), .Gnt (gnt_rr), .Vld (vld_rr)
    );

    priority_arbiter_n #(.N(8), .RR_MODE(0)) dut_fx (
        .clk (clk), .rst (rst), .D (d8), .Ack (ack),
        .Y (y_fx), .Gnt (gnt_fx), .Vld (vld_fx)
    );

    priority_arbiter_n #(.N(5), .RR_MODE(1)) dut_n5 (
        .clk (clk), .rst (rst), .D (d5), .Ack (ack),
        .Y (y_n5), .Gnt (gnt_n5), .Vld (vld_n5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack = 1'b0;
        d8  = 8'h00;
        d5  = 5'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ack = 1'b1;
        d8  = 8'hFF;
        d5  = 5'h1F;
        tick();
        tick();
        checks++;
        if ({vld_rr, y_rr, gnt_rr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rr: vld=%0b y=%0d gnt=%h, want vld=0 y=0 gnt=00", vld_rr, y_rr, gnt_rr);
        end
        checks++;
        if ({vld_fx, y_fx, gnt_fx} !== 12'h000) begin
            errors++;
            $display("FAIL reset_fx: vld=%0b y=%0d gnt=%h, want vld=0 y=0 gnt=00", vld_fx, y_fx, gnt_fx);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (vld_rr !== 1'b1 || y_rr !== 3'd7 || gnt_rr !== 8'h80) begin
            errors++;
            $display("FAIL reset_release: vld=%0b y=%0d gnt=%h, want vld=1 y=7 gnt=80", vld_rr, y_rr, gnt_rr);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        d8  = 8'b0010_1100;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (vld_fx !== 1'b1 || y_fx !== 3'd5 || gnt_fx !== 8'h20) begin
                errors++;
                $display("FAIL fixed[%0d]: vld=%0b y=%0d gnt=%h, want vld=1 y=5 gnt=20", i, vld_fx, y_fx, gnt_fx);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        d8  = 8'h0C;
        ack = 1'b0;
        tick();
        checks++;
        if (vld_fx !== 1'b1 || y_fx !== 3'd3 || gnt_fx !== 8'h08) begin
            errors++;
            $display("FAIL hold_first: vld=%0b y=%0d gnt=%h, want vld=1 y=3 gnt=08", vld_fx, y_fx, gnt_fx);
        end
        d8 = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vld_fx !== 1'b1 || y_fx !== 3'd3 || gnt_fx !== 8'h08) begin
                errors++;
                $display("FAIL hold[%0d]: vld=%0b y=%0d gnt=%h, want vld=1 y=3 gnt=08", i, vld_fx, y_fx, gnt_fx);
            end
        end
        ack = 1'b1;
        tick();
        checks++;
        if (vld_fx !== 1'b1 || y_fx !== 3'd7 || gnt_fx !== 8'h80) begin
            errors++;
            $display("FAIL hold_release: vld=%0b y=%0d gnt=%h, want vld=1 y=7 gnt=80", vld_fx, y_fx, gnt_fx);
        end
    endtask

    task automatic test_rr_sweep();
        logic [2:0] exp_y [9];
        logic [7:0] exp_g;
        exp_y = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        do_reset();
        d8  = 8'hFF;
        ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_g = 8'h01 << exp_y[i];
            checks++;
            if (vld_rr !== 1'b1 || y_rr !== exp_y[i] || gnt_rr !== exp_g) begin
                errors++;
                $display("FAIL rr_sweep[%0d]: vld=%0b y=%0d gnt=%h, want vld=1 y=%0d gnt=%h", i, vld_rr, y_rr, gnt_rr, exp_y[i], exp_g);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [2:0] exp_y [4];
        exp_y = '{3'd7, 3'd0, 3'd7, 3'd0};
        do_reset();
        d8  = 8'h81;
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (vld_rr !== 1'b1 || y_rr !== exp_y[i]) begin
                errors++;
                $display("FAIL rr_sparse[%0d]: vld=%0b y=%0d, want vld=1 y=%0d", i, vld_rr, y_rr, exp_y[i]);
            end
        end
        d8 = 8'h00;
        tick();
        checks++;
        if ({vld_rr, y_rr, gnt_rr} !== 12'h000) begin
            errors++;
            $display("FAIL rr_idle: vld=%0b y=%0d gnt=%h, want vld=0 y=0 gnt=00", vld_rr, y_rr, gnt_rr);
        end
        tick();
        checks++;
        if ({vld_rr, y_rr, gnt_rr} !== 12'h000) begin
            errors++;
            $display("FAIL ack_ignored: vld=%0b y=%0d gnt=%h, want vld=0 y=0 gnt=00", vld_rr, y_rr, gnt_rr);
        end
    endtask

    task automatic test_single();
        do_reset();
        d8  = 8'h04;
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (vld_rr !== 1'b1 || y_rr !== 3'd2 || gnt_rr !== 8'h04) begin
                errors++;
                $display("FAIL single[%0d]: vld=%0b y=%0d gnt=%h, want vld=1 y=2 gnt=04", i, vld_rr, y_rr, gnt_rr);
            end
        end
    endtask

    task automatic test_mid_hold_reset();
        do_reset();
        d8  = 8'h20;
        ack = 1'b0;
        tick();
        tick();
        checks++;
        if (vld_rr !== 1'b1 || y_rr !== 3'd5) begin
            errors++;
            $display("FAIL midrst_hold: vld=%0b y=%0d, want vld=1 y=5", vld_rr, y_rr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({vld_rr, y_rr, gnt_rr} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_clear: vld=%0b y=%0d gnt=%h, want vld=0 y=0 gnt=00", vld_rr, y_rr, gnt_rr);
        end
        rst = 1'b0;
        d8  = 8'hFF;
        ack = 1'b1;
        tick();
        checks++;
        if (vld_rr !== 1'b1 || y_rr !== 3'd7) begin
            errors++;
            $display("FAIL midrst_after: vld=%0b y=%0d, want vld=1 y=7", vld_rr, y_rr);
        end
    endtask

    task automatic test_odd_n();
        logic [2:0] exp_y [6];
        logic [4:0] exp_g;
        exp_y = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        do_reset();
        d5  = 5'h1F;
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_g = 5'h01 << exp_y[i];
            checks++;
            if (vld_n5 !== 1'b1 || y_n5 !== exp_y[i] || gnt_n5 !== exp_g) begin
                errors++;
                $display("FAIL odd_n[%0d]: vld=%0b y=%0d gnt=%h, want vld=1 y=%0d gnt=%h", i, vld_n5, y_n5, gnt_n5, exp_y[i], exp_g);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ack    = 1'b0;
        d8     = 8'h00;
        d5     = 5'h00;
        #2;
        test_reset();
        test_fixed();
        test_hold();
        test_rr_sweep();
        test_rr_sparse();
        test_single();
        test_mid_hold_reset();
        test_odd_n();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
